// File: rtl/shift_register_univ.sv
// Universal loadable shift/rotate register with single-step opcodes and a
// multi-cycle shift engine (start/busy/done) that shifts one bit per cycle.
module shift_register_univ #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_SHL   = 3'b010;
    localparam logic [2:0] OP_SHR   = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [2:0]       op_lat;
    logic [AMT_W-1:0] cnt;

    function automatic logic is_shift_op(input logic [2:0] o);
        return (o >= OP_SHL) && (o <= OP_ASR);
    endfunction

    // Returns {so, q} after applying one operation to the current contents.
    function automatic logic [WIDTH:0] apply_op(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] v,
        input logic             s,
        input logic [WIDTH-1:0] din,
        input logic             so_cur
    );
        logic [WIDTH:0] r;
        case (o)
            OP_HOLD:  r = {so_cur, v};
            OP_LOAD:  r = {so_cur, din};
            OP_SHL:   r = {v[WIDTH-1], v[WIDTH-2:0], s};
            OP_SHR:   r = {v[0], s, v[WIDTH-1:1]};
            OP_ROL:   r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:   r = {v[0], v[0], v[WIDTH-1:1]};
            OP_ASR:   r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_CLEAR: r = {so_cur, {WIDTH{1'b0}}};
            default:  r = {so_cur, v};
        endcase
        return r;
    endfunction

    assign busy = (state == ST_RUN);

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // pre-edge values; blocking assignments would chain updates within one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q      <= '0;
            so     <= 1'b0;
            done   <= 1'b0;
            state  <= ST_IDLE;
            op_lat <= OP_HOLD;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start && is_shift_op(op)) begin
                    // Latch the request; data is untouched on the accepting edge.
                    op_lat <= op;
                    cnt    <= amt;
                    if (amt != '0) begin
                        state <= ST_RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end else begin
                    {so, q} <= apply_op(op, q, si, d, so);
                end
            end else begin
                {so, q} <= apply_op(op_lat, q, si, d, so);
                cnt     <= cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/shift_register_univ.md
# shift_register_univ

Parametrised universal register, the successor to the fixed 32-bit plain D register. It adds asynchronous active-low reset and an opcode-selected single-cycle operation: hold, load, logical/arithmetic shift, rotate or clear. It also adds a multi-cycle shift engine that shifts by a programmable amount, one bit per cycle, with a start/busy/done handshake. It sits in the datapath wherever a loadable shifter/serialiser register is needed.

## Interface
- WIDTH, 32, register width in bits (≥2)
- AMT_W, 5, width of shift-amount port; 2^AMT_W ≥ WIDTH required

- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- op  input  3  operation select (encoding below)
- d  input  WIDTH  parallel load data
- si  input  1  serial input bit for SHL/SHR
- start  input  1  request multi-cycle shift using op and amt
- amt  input  AMT_W  multi-cycle shift count
- q  output  WIDTH  register contents
- so  output  1  last bit shifted/rotated out (registered)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse: multi-cycle shift finished

## Operation
- Opcodes:
  - 000 HOLD
  - 001 LOAD (q←d)
  - 010 SHL (q←{q[W-2:0],si}, so←q[W-1])
  - 011 SHR (q←{si,q[W-1:1]}, so←q[0])
  - 100 ROL (so←q[W-1])
  - 101 ROR (so←q[0])
  - 110 ASR (MSB replicated, so←q[0])
  - 111 CLEAR (q←0)
- so changes only on shift/rotate ops; holds on HOLD/LOAD/CLEAR.
- IDLE, start=0: op executes every cycle (single-step mode).
- IDLE, start=1, op ∈ {SHL,SHR,ROL,ROR,ASR}: op and amt latched, no data change this edge.
  - amt≠0 → RUN, busy=1.
  - amt=0 → stay IDLE, done=1, q unchanged.
- IDLE, start=1, op ∉ shift set: start ignored; op executes as single-step.
- RUN: one shift of latched op per edge, counter decremented. si sampled at each shift edge. On the edge performing the last shift: → IDLE, busy=0, done=1.
- While busy: op, d, start, amt ignored (start not queued).
- done is high exactly one cycle. During that cycle the FSM is IDLE and a new op/start is accepted.
- Counter is AMT_W bits; no wrap, it stops at the final shift.

## Timing
- Reset (reset_n=0, immediate, clock-independent): q=0, so=0, busy=0, done=0, FSM IDLE, latched op/count cleared.
- Reset mid-RUN aborts. No done pulse afterwards. Partial shift result is discarded (q=0).
- Single-step latency: 1 cycle (result visible after the edge sampling op).
- Multi-cycle, start sampled at edge E with amt=N>0:
  - busy=1 after E.
  - Shifts at E+1…E+N.
  - After E+N: busy=0, done=1; done clears after E+N+1 unless a new amt=0 start sets it again.
  - Total start-to-done: N+1 cycles.
- amt=0: done=1 after E, busy never asserted.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset/load: reset_n low mid-cycle → q=0 immediately. LOAD d=A5A5A5A5 → q=A5A5A5A5. HOLD 3 cycles → unchanged, so=0.
- Single-step ops, starting from q=12345678:
  - SHL si=1 → q=2468ACF1, so=0.
  - Reload 12345678, ROR → q=091A2B3C, so=0.
  - q=80000001, ASR → q=C0000000, so=1.
  - CLEAR → q=0.
- Multi-cycle rotate: q=12345678, start ROL amt=8 → busy high 8 cycles. q=34567812 with done high on cycle 9 only. op=LOAD with start=1 applied while busy → no effect.
- Boundaries:
  - amt=0 start → done next cycle, busy never high, q unchanged.
  - q=FFFFFFFF, SHR si=0 amt=31 → q=00000001, so=1.
  - q=80000000, ASR amt=31 → q=FFFFFFFF.
- Reset mid-run: start SHL amt=10, assert reset_n=0 after 3 shifts → q=0, busy=0, done never pulses. After release, LOAD works normally.
- Back-to-back: in the done cycle of one run, start ROR amt=4 → accepted; second done exactly 5 cycles later.
